clksw_ctrl: RTL and testbench

Clock-switch sequencer that drives the select lines of the chip's glitch-free clock mux and confirms each switch from the mux's own per-source enable status. It sits in the always-on clock domain, takes one switch request at a time over a valid/ready handshake, and runs break-before-make. Every source's enable must be confirmed low before the target's select is raised. Completion is signalled by a done pulse; a stuck mux is flagged as a sticky error.

---
 rtl/clksw_pkg.sv | 23 ++
 rtl/clksw_if.sv | 15 +
 rtl/clksw_sync.sv | 22 ++
 rtl/clksw_ctrl.sv | 148 ++++++++++++++
 tb/tb_clksw_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/clksw_pkg.sv
// Shared types, defaults and helpers for the clock-switch sequencer.
package clksw_pkg;

   localparam int NUMCLK_DEF      = 2;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int TO_CYCLES_DEF   = 255;
   localparam int RESET_SEL_DEF   = 0;
   localparam int MAXCLK          = 8;
   localparam int MAX_IW          = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OFF  = 2'd1,
      ST_ON   = 2'd2,
      ST_FAIL = 2'd3
   } state_e;

   // Widest one-hot; callers size-cast down to their own source count.
   function automatic logic [MAXCLK-1:0] onehot(input logic [MAX_IW-1:0] idx);
      onehot = 8'b0000_0001 << idx;
   endfunction

endpackage

// File: rtl/clksw_if.sv
// Switch-request handshake between a requester and the clock-switch sequencer.
interface clksw_if
   import clksw_pkg::*;
#(
   parameter int NUMCLK = NUMCLK_DEF
);
   localparam int IW = $clog2(NUMCLK);

   logic          req_valid;
   logic [IW-1:0] req_idx;
   logic          req_ready;

   modport master (output req_valid, output req_idx, input  req_ready);
   modport slave  (input  req_valid, input  req_idx, output req_ready);
endinterface

// File: rtl/clksw_sync.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
module clksw_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);
   logic [STAGES-1:0] ff_q;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff_q <= '0;
      end else begin
         ff_q <= {ff_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/clksw_ctrl.sv
// Break-before-make clock-switch sequencer driving a glitch-free clock mux.
// Every select change is confirmed from the mux's synchronized enable status.
module clksw_ctrl
   import clksw_pkg::*;
#(
   parameter int NUMCLK      = NUMCLK_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int TO_CYCLES   = TO_CYCLES_DEF,
   parameter int RESET_SEL   = RESET_SEL_DEF,
   localparam int IW         = $clog2(NUMCLK)
) (
   input  logic              clk,
   input  logic              rst_n,
   clksw_if.slave            req,
   output logic [NUMCLK-1:0] sel,
   input  logic [NUMCLK-1:0] clk_active,
   output logic [IW-1:0]     cur_idx,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic              err_clr
);
   localparam int                CW        = $clog2(TO_CYCLES + 1);
   localparam logic [CW-1:0]     CNT_LAST  = CW'(TO_CYCLES - 1);
   localparam logic [NUMCLK-1:0] RESET_OH  = NUMCLK'(onehot(MAX_IW'(RESET_SEL)));
   localparam logic [IW-1:0]     RESET_IDX = IW'(RESET_SEL);

   state_e            state_q, state_d;
   logic [NUMCLK-1:0] sel_q, sel_d;
   logic [IW-1:0]     cur_q, cur_d;
   logic [IW-1:0]     tgt_q, tgt_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              err_set_s;
   logic [NUMCLK-1:0] act_s;
   logic [NUMCLK-1:0] tgt_oh_s;
   logic [CW-1:0]     cnt_inc_s;
   logic              timeout_s;
   logic              idx_bad_s;

   for (genvar i = 0; i < NUMCLK; i++) begin : g_sync
      clksw_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d_i   (clk_active[i]),
         .q_o   (act_s[i])
      );
   end

   assign tgt_oh_s  = NUMCLK'(onehot(MAX_IW'(tgt_q)));
   assign timeout_s = (cnt_q == CNT_LAST);
   assign cnt_inc_s = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
   assign idx_bad_s = (32'(req.req_idx) >= 32'(NUMCLK));

   // Next-state, select, counter and completion decode.
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      cur_d     = cur_q;
      tgt_d     = tgt_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      err_set_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req.req_valid) begin
               if (idx_bad_s) begin
                  err_set_s = 1'b1;
               end else if (req.req_idx == cur_q) begin
                  done_d = 1'b1;
               end else begin
                  tgt_d   = req.req_idx;
                  sel_d   = '0;
                  cnt_d   = '0;
                  state_d = ST_OFF;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OFF: begin
            if (act_s == '0) begin
               sel_d   = tgt_oh_s;
               cnt_d   = '0;
               state_d = ST_ON;
            end else if (timeout_s) begin
               state_d = ST_FAIL;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         ST_ON: begin
            if (act_s == tgt_oh_s) begin
               cur_d   = tgt_q;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (timeout_s) begin
               state_d = ST_FAIL;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         ST_FAIL: begin
            // The old source stays recorded; software has to re-request.
            sel_d     = '0;
            err_set_s = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q | err_set_s;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= RESET_OH;
         cur_q   <= RESET_IDX;
         tgt_q   <= RESET_IDX;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign req.req_ready = (state_q == ST_IDLE);
   assign busy          = (state_q != ST_IDLE);
   assign sel           = sel_q;
   assign cur_idx       = cur_q;
   assign done          = done_q;
   assign err           = err_q;
endmodule

// File: tb/tb_clksw_ctrl.sv
// Directed bench for clksw_ctrl against a phase/elapsed-time model and a delayed-mux model.
module tb_clksw_ctrl;
   // Three sources so that index 3 is representable and out of range.
   localparam int NUMCLK = 3;
   localparam int SYNC   = 2;
   localparam int TO     = 8;
   localparam int RSEL   = 0;

   localparam int PH_IDLE  = 0;
   localparam int PH_BREAK = 10;
   localparam int PH_MAKE  = 20;
   localparam int PH_ABORT = 30;

   typedef struct packed {
      int         phase;
      int         tgt;
      int         cur;
      int         elapsed;
      logic [2:0] sel;
      logic       done;
      logic       err;
      logic [2:0] h1;
      logic [2:0] h2;
   } model_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] sel;
   logic [2:0] clk_active;
   logic [1:0] cur_idx;
   logic       busy, done, err;
   logic       err_clr = 1'b0;
   logic [2:0] stuck = 3'b000;
   logic [2:0] mx0, mx1, mx2;
   model_t     m;
   int         checks = 0;
   int         passes = 0;

   clksw_if #(.NUMCLK(NUMCLK)) bus ();

   clksw_ctrl #(.NUMCLK(NUMCLK), .SYNC_STAGES(SYNC), .TO_CYCLES(TO), .RESET_SEL(RSEL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (bus.slave),
      .sel        (sel),
      .clk_active (clk_active),
      .cur_idx    (cur_idx),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   // Mux model: enable status follows sel three clk cycles later; stuck forces bits high.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mx0 <= 3'b001;
         mx1 <= 3'b001;
         mx2 <= 3'b001;
      end else begin
         mx0 <= sel;
         mx1 <= mx0;
         mx2 <= mx1;
      end
   end
   assign clk_active = mx2 | stuck;

   function automatic model_t model_reset();
      model_t n;
      n.phase = PH_IDLE; n.tgt = RSEL; n.cur = RSEL; n.elapsed = 0;
      n.sel = 3'b001 << RSEL; n.done = 1'b0; n.err = 1'b0;
      n.h1 = 3'b000; n.h2 = 3'b000;
      return n;
   endfunction

   // elapsed counts cycles spent in the current phase, 1 on its first cycle.
   function automatic model_t model_step(model_t m0, logic v, logic [1:0] idx,
                                         logic [2:0] act, logic clr);
      model_t     n = m0;
      logic       set_err = 1'b0;
      logic [2:0] want = 3'b001 << m0.tgt;
      n.done = 1'b0;
      n.h1   = act;
      n.h2   = m0.h1;
      case (m0.phase)
         PH_IDLE: if (v) begin
            if (int'(idx) >= NUMCLK) set_err = 1'b1;
            else if (int'(idx) == m0.cur) n.done = 1'b1;
            else begin
               n.tgt = int'(idx); n.sel = 3'b000; n.elapsed = 1; n.phase = PH_BREAK;
            end
         end
         PH_BREAK: begin
            if (m0.h2 == 3'b000) begin
               n.sel = want; n.elapsed = 1; n.phase = PH_MAKE;
            end else if (m0.elapsed == TO) n.phase = PH_ABORT;
            else n.elapsed = m0.elapsed + 1;
         end
         PH_MAKE: begin
            if (m0.h2 == want) begin
               n.cur = m0.tgt; n.done = 1'b1; n.phase = PH_IDLE;
            end else if (m0.elapsed == TO) n.phase = PH_ABORT;
            else n.elapsed = m0.elapsed + 1;
         end
         PH_ABORT: begin
            n.sel = 3'b000; set_err = 1'b1; n.phase = PH_IDLE;
         end
         default: n.phase = PH_IDLE;
      endcase
      n.err = clr ? 1'b0 : (m0.err | set_err);
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else m <= model_step(m, bus.req_valid, bus.req_idx, clk_active, err_clr);
   end

   // Cycle compare: {ready, busy, done, err, cur_idx, sel} against the model.
   always @(negedge clk) begin
      logic [8:0] got, want;
      got  = {bus.req_ready, busy, done, err, cur_idx, sel};
      want = {m.phase == PH_IDLE, m.phase != PH_IDLE, m.done, m.err, 2'(m.cur), m.sel};
      checks++;
      if (got !== want)
         $display("FAIL cycle_model t=%0t got %b want %b", $time, got, want);
      else
         passes++;
   end

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) $display("FAIL %s got %0d want %0d", name, got, want);
      else passes++;
   endtask

   // Pulse one request and record, in cycles after the accept edge, the first
   // appearance of want_sel, of done and of err, plus the number of done pulses.
   task automatic issue(input logic [1:0] idx, input int span, input logic [2:0] want_sel,
                        output int k_sel, output int k_done, output int k_err,
                        output int n_done, output logic [2:0] sel1);
      k_sel = -1; k_done = -1; k_err = -1; n_done = 0; sel1 = 3'b000;
      bus.req_idx   = idx;
      bus.req_valid = 1'b1;
      for (int k = 1; k <= span; k++) begin
         @(negedge clk);
         if (k == 1) begin
            bus.req_valid = 1'b0;
            sel1 = sel;
         end
         if (k_sel < 0 && sel == want_sel) k_sel = k;
         if (done) begin
            n_done++;
            if (k_done < 0) k_done = k;
         end
         if (k_err < 0 && err) k_err = k;
      end
   endtask

   initial begin
      int         ks, kd, ke, nd, n_acc, n_dn;
      logic [2:0] s1;
      bus.req_valid = 1'b0;
      bus.req_idx   = 2'd0;
      repeat (3) @(negedge clk);
      chk("rst_sel", int'(sel), 1);
      chk("rst_cur", int'(cur_idx), 0);
      chk("rst_ready", int'(bus.req_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_err", int'(err), 0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      // 0 -> 1: each phase waits 3 mux cycles + 2 sync cycles + 1 decision edge,
      // so sel=010 at accept+7 and done at accept+13.
      issue(2'd1, 20, 3'b010, ks, kd, ke, nd, s1);
      chk("sw01_sel_break", int'(s1), 0);
      chk("sw01_sel_make_cycle", ks, 7);
      chk("sw01_done_cycle", kd, 13);
      chk("sw01_done_count", nd, 1);
      chk("sw01_no_err", ke, -1);
      chk("sw01_cur", int'(cur_idx), 1);

      issue(2'd1, 6, 3'b010, ks, kd, ke, nd, s1);
      chk("same_done_cycle", kd, 1);
      chk("same_done_count", nd, 1);
      chk("same_sel_held", int'(s1), 2);
      chk("same_sel_end", int'(sel), 2);

      issue(2'd3, 4, 3'b010, ks, kd, ke, nd, s1);
      chk("bad_err_cycle", ke, 1);
      chk("bad_sel_held", int'(s1), 2);
      chk("bad_no_done", nd, 0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("errclr", int'(err), 0);

      err_clr = 1'b1;
      issue(2'd3, 3, 3'b010, ks, kd, ke, nd, s1);
      err_clr = 1'b0;
      chk("errclr_priority", ke, -1);

      issue(2'd0, 20, 3'b001, ks, kd, ke, nd, s1);
      chk("sw10_done_cycle", kd, 13);
      chk("sw10_cur", int'(cur_idx), 0);

      // Source 0 never reports off: FAIL after 8 OFF cycles, err one cycle later.
      stuck = 3'b001;
      issue(2'd1, 16, 3'b010, ks, kd, ke, nd, s1);
      chk("stuck_err_cycle", ke, 10);
      chk("stuck_no_done", nd, 0);
      chk("stuck_never_sel", ks, -1);
      chk("stuck_sel", int'(sel), 0);
      chk("stuck_cur", int'(cur_idx), 0);
      chk("stuck_busy", int'(busy), 0);
      stuck = 3'b000;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      repeat (6) @(negedge clk);

      // Mux status is already all-off, so ON is entered one cycle after accept.
      bus.req_idx   = 2'd1;
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("on_before_rst", int'(sel), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_sel", int'(sel), 1);
      chk("arst_busy", int'(busy), 0);
      chk("arst_cur", int'(cur_idx), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      issue(2'd1, 20, 3'b010, ks, kd, ke, nd, s1);
      chk("post_rst_done_cycle", kd, 13);
      chk("post_rst_cur", int'(cur_idx), 1);

      // Held request: index changes while busy are ignored; second accept only after done.
      n_acc = 0;
      n_dn  = 0;
      bus.req_idx   = 2'd0;
      bus.req_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (bus.req_valid && bus.req_ready) n_acc++;
         @(negedge clk);
         bus.req_idx = 2'd1;
         if (n_acc == 2) bus.req_valid = 1'b0;
         if (done) n_dn++;
      end
      chk("held_accepts", n_acc, 2);
      chk("held_dones", n_dn, 2);
      chk("held_cur", int'(cur_idx), 1);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation exceeded its time limit");
      $fatal(1);
   end
endmodule
